transport_link_arbiter: RTL and testbench

//  Shares one transportSend instance between two session-side requesters (req0, req1),
//  e.g. a call-control session and an audio-streaming session on the same node.

---
 rtl/transport_link_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_transport_link_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transport_link_arbiter.sv
// Shares one transportSend port between two requesters: word-at-a-time issue paced on tx_busy,
// burst-limited round robin, control words preempting audio at word boundaries.
module transport_link_arbiter #(
  parameter int unsigned MAX_BURST  = 4,
  parameter logic [1:0]  AUDIO_CMD  = 2'b11,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [1:0]  req0_cmd,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [1:0]  req1_cmd,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic [1:0]  tx_cmd,
  output logic [15:0] tx_data,
  input  logic        tx_busy,
  output logic        owner,
  output logic [7:0]  burst_cnt,
  output logic        drop_err
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StIssue    = 3'd1;
  localparam logic [2:0] StWaitBusy = 3'd2;
  localparam logic [2:0] StWaitDone = 3'd3;
  localparam logic [2:0] StGap      = 3'd4;

  localparam logic [2:0] StAfterTx = (GAP_CYCLES == 0) ? StIdle : StGap;

  logic [2:0]  stateQ, stateD;
  logic [1:0]  waitCntQ, waitCntD;
  logic [3:0]  gapCntQ, gapCntD;
  logic        ownerQ, ownerD;
  logic [7:0]  burstQ, burstD;
  logic [1:0]  txCmdQ, txCmdD;
  logic [15:0] txDataQ, txDataD;
  logic        ready0Q, ready0D;
  logic        ready1Q, ready1D;
  logic        dropErrQ, dropErrD;

  // A requester whose ready is pulsing this cycle still shows its old word; ignore it.
  logic elig0, elig1;
  logic drop0, drop1;
  logic legal0, legal1;
  logic ctrl0, ctrl1;
  logic ownerLegal, otherLegal, burstOpen;
  logic sel;

  assign elig0  = req0_valid && !ready0Q;
  assign elig1  = req1_valid && !ready1Q;
  assign drop0  = elig0 && (req0_cmd == 2'b00);
  assign drop1  = elig1 && (req1_cmd == 2'b00);
  assign legal0 = elig0 && (req0_cmd != 2'b00);
  assign legal1 = elig1 && (req1_cmd != 2'b00);
  assign ctrl0  = legal0 && (req0_cmd != AUDIO_CMD);
  assign ctrl1  = legal1 && (req1_cmd != AUDIO_CMD);

  assign ownerLegal = ownerQ ? legal1 : legal0;
  assign otherLegal = ownerQ ? legal0 : legal1;
  // burst_cnt==0 means no burst in progress, so the reset owner=1 hands the first tie to req0.
  assign burstOpen  = (burstQ != 8'd0) && (32'(burstQ) < MAX_BURST);

  always_comb begin
    sel = ~ownerQ;
    if (ctrl0 ^ ctrl1) begin
      sel = ctrl1;
    end else if (ctrl0 && ctrl1) begin
      sel = ~ownerQ;
    end else if (ownerLegal && (burstOpen || !otherLegal)) begin
      sel = ownerQ;
    end else begin
      sel = ~ownerQ;
    end
  end

  always_comb begin
    stateD   = stateQ;
    waitCntD = waitCntQ;
    gapCntD  = gapCntQ;
    ownerD   = ownerQ;
    burstD   = burstQ;
    txCmdD   = 2'b00;
    txDataD  = txDataQ;
    ready0D  = 1'b0;
    ready1D  = 1'b0;
    dropErrD = dropErrQ;
    case (stateQ)
      StIdle: begin
        if (drop0 || drop1) begin
          dropErrD = 1'b1;
          if (drop0) begin
            ready0D = 1'b1;
          end else begin
            ready1D = 1'b1;
          end
        end else if (!tx_busy && (legal0 || legal1)) begin
          stateD  = StIssue;
          txCmdD  = sel ? req1_cmd : req0_cmd;
          txDataD = sel ? req1_data : req0_data;
          ready0D = ~sel;
          ready1D = sel;
          if (sel != ownerQ) begin
            ownerD = sel;
            burstD = 8'd1;
          end else if (burstQ != 8'hFF) begin
            burstD = burstQ + 8'd1;
          end
        end
      end
      StIssue: begin
        stateD   = StWaitBusy;
        waitCntD = 2'd0;
      end
      StWaitBusy: begin
        if (tx_busy) begin
          stateD = StWaitDone;
        end else if (waitCntQ == 2'd3) begin
          // transportSend never went busy; treat the word as accepted.
          stateD  = StAfterTx;
          gapCntD = 4'd0;
        end else begin
          waitCntD = waitCntQ + 2'd1;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          stateD  = StAfterTx;
          gapCntD = 4'd0;
        end
      end
      StGap: begin
        if (32'(gapCntQ) == GAP_CYCLES - 1) begin
          stateD = StIdle;
        end else begin
          gapCntD = gapCntQ + 4'd1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ   <= StIdle;
      waitCntQ <= 2'd0;
      gapCntQ  <= 4'd0;
      ownerQ   <= 1'b1;
      burstQ   <= 8'd0;
      txCmdQ   <= 2'b00;
      txDataQ  <= 16'd0;
      ready0Q  <= 1'b0;
      ready1Q  <= 1'b0;
      dropErrQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      waitCntQ <= waitCntD;
      gapCntQ  <= gapCntD;
      ownerQ   <= ownerD;
      burstQ   <= burstD;
      txCmdQ   <= txCmdD;
      txDataQ  <= txDataD;
      ready0Q  <= ready0D;
      ready1Q  <= ready1D;
      dropErrQ <= dropErrD;
    end
  end

  assign req0_ready = ready0Q;
  assign req1_ready = ready1Q;
  assign tx_cmd     = txCmdQ;
  assign tx_data    = txDataQ;
  assign owner      = ownerQ;
  assign burst_cnt  = burstQ;
  assign drop_err   = dropErrQ;

endmodule

// File: tb/tb_transport_link_arbiter.sv
// Directed bench for transport_link_arbiter with a small transportSend busy model and issue log.
module tb_transport_link_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [1:0]  req0_cmd = 2'b00;
  logic [15:0] req0_data = 16'd0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [1:0]  req1_cmd = 2'b00;
  logic [15:0] req1_data = 16'd0;
  logic        req1_ready;
  logic [1:0]  tx_cmd;
  logic [15:0] tx_data;
  logic        tx_busy = 1'b0;
  logic        owner;
  logic [7:0]  burst_cnt;
  logic        drop_err;

  transport_link_arbiter #(
    .MAX_BURST (4),
    .AUDIO_CMD (2'b11),
    .GAP_CYCLES(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_cmd  (req0_cmd),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_cmd  (req1_cmd),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .tx_cmd    (tx_cmd),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .owner     (owner),
    .burst_cnt (burst_cnt),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass = 0;
  int cyc = 0;
  int busyLen = 2;
  int busyRem = 0;
  logic busyHold = 1'b0;
  int r0Cnt = 0;
  int r1Cnt = 0;
  int longPulse = 0;
  logic prevCmdNz = 1'b0;

  logic [1:0]  logCmd[$];
  logic [15:0] logData[$];
  logic        logSrc[$];
  logic        logOwner[$];
  logic [7:0]  logBurst[$];
  int          logCyc[$];

  task automatic check(input string tag, input int got, input int exp);
    nChecks++;
    if (got == exp) begin
      nPass++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // transportSend model: busy for busyLen cycles after each word, or held by busyHold.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_cmd != 2'b00 && busyLen != 0) begin
        busyRem = busyLen;
      end else if (busyRem != 0) begin
        busyRem--;
      end
      tx_busy = busyHold || (busyRem != 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (req0_ready) r0Cnt++;
      if (req1_ready) r1Cnt++;
      if (tx_cmd != 2'b00) begin
        if (prevCmdNz) longPulse++;
        logCmd.push_back(tx_cmd);
        logData.push_back(tx_data);
        logSrc.push_back(req1_ready);
        logOwner.push_back(owner);
        logBurst.push_back(burst_cnt);
        logCyc.push_back(cyc);
      end
      prevCmdNz = (tx_cmd != 2'b00);
    end
  end

  task automatic clearLog();
    logCmd.delete();
    logData.delete();
    logSrc.delete();
    logOwner.delete();
    logBurst.delete();
    logCyc.delete();
    r0Cnt = 0;
    r1Cnt = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clearLog();
  endtask

  task automatic sendWord(input int which, input logic [1:0] cmd, input logic [15:0] data,
                          input int bound);
    logic got;
    got = 1'b0;
    if (which == 0) begin
      req0_valid = 1'b1;
      req0_cmd   = cmd;
      req0_data  = data;
    end else begin
      req1_valid = 1'b1;
      req1_cmd   = cmd;
      req1_data  = data;
    end
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      got = (which == 0) ? req0_ready : req1_ready;
    end
    if (which == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
    check($sformatf("handshake_req%0d", which), int'(got), 1);
  endtask

  initial begin
    int n;
    // Reset state
    doReset();
    check("rst_tx_cmd", int'(tx_cmd), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_ready0", int'(req0_ready), 0);
    check("rst_ready1", int'(req1_ready), 0);
    check("rst_owner", int'(owner), 1);
    check("rst_burst", int'(burst_cnt), 0);
    check("rst_drop_err", int'(drop_err), 0);

    // Three audio words from req0, 2-cycle busy each
    busyLen = 2;
    for (int i = 0; i < 3; i++) sendWord(0, 2'b11, 16'hC001 + 16'(i), 40);
    repeat (10) @(negedge clk);
    check("t1_count", logData.size(), 3);
    check("t1_ready0", r0Cnt, 3);
    check("t1_ready1", r1Cnt, 0);
    for (int i = 0; i < 3 && i < logData.size(); i++) begin
      check($sformatf("t1_cmd%0d", i), int'(logCmd[i]), 3);
      check($sformatf("t1_data%0d", i), int'(logData[i]), 'hC001 + i);
    end
    check("t1_burst", int'(burst_cnt), 3);
    check("t1_owner", int'(owner), 0);
    check("t1_idle_cmd", int'(tx_cmd), 0);
    check("t1_data_held", int'(tx_data), 'hC003);

    // Both stream audio: four-word bursts alternate, req0 first
    doReset();
    fork
      for (int i = 0; i < 8; i++) sendWord(0, 2'b11, 16'h0A00 + 16'(i), 200);
      for (int i = 0; i < 8; i++) sendWord(1, 2'b11, 16'h1B00 + 16'(i), 200);
    join
    repeat (10) @(negedge clk);
    check("t2_count", logData.size(), 16);
    for (int i = 0; i < 16 && i < logData.size(); i++) begin
      int expSrc;
      int expIdx;
      expSrc = (i / 4) % 2;
      expIdx = (i / 8) * 4 + (i % 4);
      check($sformatf("t2_src%0d", i), int'(logSrc[i]), expSrc);
      check($sformatf("t2_owner%0d", i), int'(logOwner[i]), expSrc);
      check($sformatf("t2_burst%0d", i), int'(logBurst[i]), (i % 4) + 1);
      check($sformatf("t2_data%0d", i), int'(logData[i]),
            (expSrc == 0 ? 'h0A00 : 'h1B00) + expIdx);
    end

    // Control word on req0 preempts req1's audio burst at burst_cnt=1
    doReset();
    sendWord(1, 2'b11, 16'h1111, 40);
    check("t3_pre_owner", int'(owner), 1);
    check("t3_pre_burst", int'(burst_cnt), 1);
    fork
      sendWord(1, 2'b11, 16'h2222, 80);
      sendWord(0, 2'b01, 16'hA5A5, 80);
    join
    repeat (10) @(negedge clk);
    check("t3_count", logData.size(), 3);
    if (logData.size() >= 3) begin
      check("t3_data", int'(logData[1]), 'hA5A5);
      check("t3_cmd", int'(logCmd[1]), 1);
      check("t3_src", int'(logSrc[1]), 0);
      check("t3_owner", int'(logOwner[1]), 0);
      check("t3_next_data", int'(logData[2]), 'h2222);
    end

    // tx_busy stuck low: 7-cycle issue period
    doReset();
    busyLen = 0;
    for (int i = 0; i < 3; i++) sendWord(0, 2'b11, 16'h7000 + 16'(i), 40);
    repeat (10) @(negedge clk);
    check("t4_count", logData.size(), 3);
    if (logData.size() >= 3) begin
      check("t4_period0", logCyc[1] - logCyc[0], 7);
      check("t4_period1", logCyc[2] - logCyc[1], 7);
    end
    busyLen = 2;

    // Illegal cmd 2'b00 is consumed and dropped
    doReset();
    sendWord(0, 2'b00, 16'hDEAD, 20);
    repeat (6) @(negedge clk);
    check("t5_no_tx", logData.size(), 0);
    check("t5_ready0", r0Cnt, 1);
    check("t5_drop_err", int'(drop_err), 1);
    check("t5_tx_data", int'(tx_data), 0);
    sendWord(1, 2'b11, 16'h5555, 40);
    repeat (6) @(negedge clk);
    check("t5_after_tx", logData.size(), 1);
    check("t5_drop_sticky", int'(drop_err), 1);
    doReset();
    check("t5_drop_cleared", int'(drop_err), 0);

    // Reset during WAIT_DONE with tx_busy held high
    sendWord(0, 2'b11, 16'h6666, 40);
    busyHold = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_tx_cmd", int'(tx_cmd), 0);
    check("t6_tx_data", int'(tx_data), 0);
    check("t6_ready0", int'(req0_ready), 0);
    check("t6_owner", int'(owner), 1);
    check("t6_burst", int'(burst_cnt), 0);
    check("t6_drop_err", int'(drop_err), 0);
    reset = 1'b0;
    clearLog();
    n = 0;
    fork
      sendWord(0, 2'b11, 16'hBEEF, 60);
      begin
        repeat (6) @(negedge clk);
        n = logData.size();
        busyHold = 1'b0;
      end
    join
    check("t6_held_off", n, 0);
    check("t6_after_release", logData.size(), 1);
    if (logData.size() >= 1) check("t6_data", int'(logData[0]), 'hBEEF);

    check("single_cycle_pulses", longPulse, 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
